// File: rtl/gyro_bias_cal.sv
// -----------------------------------------------------------------------------
// gyro_bias_cal
//   Zero-rate bias calibration for a 3-axis gyro, placed ahead of the integrator.
//   At start-up (and on a recalibration request) it averages 2^CAL_SHIFT raw
//   samples per axis to estimate the bias. After that it emits bias-corrected,
//   saturated samples, one cycle after each accepted raw sample.
//
//   Build option: define GYRO_DEADBAND_EN to force corrected samples whose
//   magnitude is below DEADBAND to zero. Without it, DEADBAND has no effect.
//
// Ports
//   clk_100mhz          system clock, rising edge
//   rst_in              synchronous active-high reset
//   raw_gx/gy/gz        raw signed 16-bit rates
//   raw_valid           one-cycle strobe qualifying raw_g*
//   recal_in            one-cycle request to restart calibration
//   gx/gy/gz            corrected signed rates (hold when out_valid is low)
//   out_valid           one-cycle strobe, gx/gy/gz updated this cycle
//   calibrated          high while a valid bias is applied
//   bias_x/y/z          current bias estimates (debug)
// -----------------------------------------------------------------------------
module gyro_bias_cal #(
  parameter int unsigned CAL_SHIFT = 8,
  parameter int unsigned DEADBAND  = 4
) (
  input  logic        clk_100mhz,
  input  logic        rst_in,
  input  logic [15:0] raw_gx,
  input  logic [15:0] raw_gy,
  input  logic [15:0] raw_gz,
  input  logic        raw_valid,
  input  logic        recal_in,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [15:0] gz,
  output logic        out_valid,
  output logic        calibrated,
  output logic [15:0] bias_x,
  output logic [15:0] bias_y,
  output logic [15:0] bias_z
);

  localparam int unsigned ACC_W = 16 + CAL_SHIFT;
  localparam int unsigned CNT_W = CAL_SHIFT;

  // Elaboration-time parameter sanity checks
  if (CAL_SHIFT < 1 || CAL_SHIFT > 12) begin : g_bad_cal_shift
    $error("gyro_bias_cal: CAL_SHIFT must be in 1..12");
  end
  if (DEADBAND > 32768) begin : g_bad_deadband
    $error("gyro_bias_cal: DEADBAND must not exceed 32768");
  end

  typedef enum logic [1:0] {
    S_CAL   = 2'd0,
    S_LATCH = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q  [3];
  logic [ACC_W-1:0]   acc_d  [3];
  logic [15:0]        bias_q [3];
  logic [15:0]        bias_d [3];
  logic [15:0]        g_q    [3];
  logic [15:0]        g_d    [3];
  logic               out_valid_q, out_valid_d;
  logic               calibrated_q, calibrated_d;
  logic [15:0]        raw_w  [3];

  assign raw_w[0] = raw_gx;
  assign raw_w[1] = raw_gy;
  assign raw_w[2] = raw_gz;

  // 17-bit difference, clamped to the signed 16-bit range
  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15]) begin
      sat_sub = d[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat_sub = d[15:0];
    end
  endfunction

`ifdef GYRO_DEADBAND_EN
  localparam logic signed [16:0] DB_POS = 17'(DEADBAND);

  // Small residual rates are treated as noise and zeroed
  function automatic logic [15:0] correct(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]        v;
    logic signed [16:0] s;
    v = sat_sub(a, b);
    s = $signed({v[15], v});
    if (s > -DB_POS && s < DB_POS) begin
      correct = 16'h0000;
    end else begin
      correct = v;
    end
  endfunction
`else
  function automatic logic [15:0] correct(input logic [15:0] a, input logic [15:0] b);
    correct = sat_sub(a, b);
  endfunction
`endif

  // State and datapath registers
  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      state_q      <= S_CAL;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      calibrated_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= '0;
        bias_q[i] <= '0;
        g_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      calibrated_q <= calibrated_d;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= acc_d[i];
        bias_q[i] <= bias_d[i];
        g_q[i]    <= g_d[i];
      end
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    calibrated_d = calibrated_q;
    for (int i = 0; i < 3; i++) begin
      acc_d[i]  = acc_q[i];
      bias_d[i] = bias_q[i];
      g_d[i]    = g_q[i];
    end

    unique case (state_q)
      S_CAL: begin
        if (recal_in) begin
          cnt_d = '0;
          for (int i = 0; i < 3; i++) acc_d[i] = '0;
        end else if (raw_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          for (int i = 0; i < 3; i++) begin
            acc_d[i] = acc_q[i] + {{CAL_SHIFT{raw_w[i][15]}}, raw_w[i]};
          end
          // Counter wraps to zero on the final sample, ready for a later recal
          if (&cnt_q) state_d = S_LATCH;
        end
      end

      S_LATCH: begin
        // Arithmetic shift floors the mean toward -inf
        for (int i = 0; i < 3; i++) begin
          bias_d[i] = 16'($signed(acc_q[i]) >>> CAL_SHIFT);
        end
        calibrated_d = 1'b1;
        state_d      = S_RUN;
      end

      S_RUN: begin
        if (recal_in) begin
          state_d      = S_CAL;
          cnt_d        = '0;
          calibrated_d = 1'b0;
          for (int i = 0; i < 3; i++) begin
            acc_d[i] = '0;
            g_d[i]   = '0;
          end
        end else if (raw_valid) begin
          out_valid_d = 1'b1;
          for (int i = 0; i < 3; i++) begin
            g_d[i] = correct(raw_w[i], bias_q[i]);
          end
        end
      end

      default: begin
        state_d = S_CAL;
      end
    endcase
  end

  assign gx         = g_q[0];
  assign gy         = g_q[1];
  assign gz         = g_q[2];
  assign out_valid  = out_valid_q;
  assign calibrated = calibrated_q;
  assign bias_x     = bias_q[0];
  assign bias_y     = bias_q[1];
  assign bias_z     = bias_q[2];

endmodule

// File: tb/tb_gyro_bias_cal.sv
// -----------------------------------------------------------------------------
// tb_gyro_bias_cal
//   Scoreboard bench for gyro_bias_cal (CAL_SHIFT=2, DEADBAND=4). A reference
//   model tracks calibration sums and bias with integer arithmetic; expected
//   corrected samples are queued with their due cycle and a monitor compares
//   them whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_gyro_bias_cal;

  localparam int CS = 2;
  localparam int N  = 4;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] raw_gx = '0, raw_gy = '0, raw_gz = '0;
  logic        raw_valid = 1'b0, recal_in = 1'b0;
  logic [15:0] gx, gy, gz, bias_x, bias_y, bias_z;
  logic        out_valid, calibrated;

  always #5 clk = ~clk;

  gyro_bias_cal #(.CAL_SHIFT(CS), .DEADBAND(DB)) dut (
    .clk_100mhz (clk),
    .rst_in     (rst_in),
    .raw_gx     (raw_gx),
    .raw_gy     (raw_gy),
    .raw_gz     (raw_gz),
    .raw_valid  (raw_valid),
    .recal_in   (recal_in),
    .gx         (gx),
    .gy         (gy),
    .gz         (gz),
    .out_valid  (out_valid),
    .calibrated (calibrated),
    .bias_x     (bias_x),
    .bias_y     (bias_y),
    .bias_z     (bias_z)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int v[3];
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string nm, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // ---------------- reference model ----------------
  // m_mode: 0 = averaging, 1 = bias latch cycle, 2 = correcting
  int m_mode = 0;
  int m_cnt  = 0;
  int m_sum[3]  = '{0, 0, 0};
  int m_bias[3] = '{0, 0, 0};
  int m_out[3]  = '{0, 0, 0};

  function automatic int floor_div(input int s);
    int q;
    q = s / N;
    if ((s % N != 0) && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic int corrected(input int raw, input int b);
    int d;
    d = raw - b;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
`ifdef GYRO_DEADBAND_EN
    if (d > -DB && d < DB) d = 0;
`endif
    return d;
  endfunction

  task automatic model_step(input int r[3], input bit v, input bit rc, input bit rs);
    exp_t e;
    if (rs) begin
      m_mode = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
        m_sum[i] = 0; m_bias[i] = 0; m_out[i] = 0;
      end
      return;
    end
    case (m_mode)
      0: begin
        if (rc) begin
          m_cnt = 0;
          for (int i = 0; i < 3; i++) m_sum[i] = 0;
        end else if (v) begin
          for (int i = 0; i < 3; i++) m_sum[i] += r[i];
          m_cnt++;
          if (m_cnt == N) m_mode = 1;
        end
      end
      1: begin
        for (int i = 0; i < 3; i++) m_bias[i] = floor_div(m_sum[i]);
        m_mode = 2;
      end
      default: begin
        if (rc) begin
          m_mode = 0; m_cnt = 0;
          for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0; m_out[i] = 0;
          end
        end else if (v) begin
          for (int i = 0; i < 3; i++) begin
            m_out[i] = corrected(r[i], m_bias[i]);
            e.v[i]   = m_out[i];
          end
          e.due = cyc + 1;
          exp_q.push_back(e);
        end
      end
    endcase
  endtask

  // One clock of stimulus; checks registered state just after the edge
  task automatic step(input int x, input int y, input int z,
                      input bit v = 1'b1, input bit rc = 1'b0, input bit rs = 1'b0);
    int r[3];
    r[0] = x; r[1] = y; r[2] = z;
    raw_gx = 16'(x); raw_gy = 16'(y); raw_gz = 16'(z);
    raw_valid = v; recal_in = rc; rst_in = rs;
    model_step(r, v, rc, rs);
    @(posedge clk);
    #1;
    raw_valid = 1'b0; recal_in = 1'b0; rst_in = 1'b0;
    chk("calibrated", int'(calibrated), (m_mode == 2) ? 1 : 0);
    chk("bias_x", s16(bias_x), m_bias[0]);
    chk("bias_y", s16(bias_y), m_bias[1]);
    chk("bias_z", s16(bias_z), m_bias[2]);
    chk("gx_hold", s16(gx), m_out[0]);
    chk("gy_hold", s16(gy), m_out[1]);
    chk("gz_hold", s16(gz), m_out[2]);
  endtask

  task automatic idle();
    step(0, 0, 0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      chk("missing_out_valid", 0, 1);
      void'(exp_q.pop_front());
    end
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_latency", cyc, e.due);
        chk("out_gx", s16(gx), e.v[0]);
        chk("out_gy", s16(gy), e.v[1]);
        chk("out_gz", s16(gz), e.v[2]);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rv[3];
    bit v, rc, rs;

    step(0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_calibrated", int'(calibrated), 0);
    chk("reset_gx", s16(gx), 0);

    // Calibration, including negative floor on Y
    step(10, -3, -100);
    step(12, -3, -100);
    step(14, -3, -100);
    step(16, -2, -100);
    chk("latch_not_yet_cal", int'(calibrated), 0);
    step(99, 99, 99, 1'b1, 1'b1);            // dropped and ignored in latch cycle
    chk("cal_rise", int'(calibrated), 1);
    chk("bias_x_13", s16(bias_x), 13);
    chk("bias_y_floor", s16(bias_y), -3);
    chk("bias_z_m100", s16(bias_z), -100);

    step(13, -3, 0);
    chk("first_out_valid", int'(out_valid), 1);
    chk("gy_zero", s16(gy), 0);
    step(13, -3, 32760);
    chk("gz_sat_pos", s16(gz), 32767);
    idle();
    chk("out_valid_drops", int'(out_valid), 0);

    // Back-to-back throughput
    for (int n = 0; n < 5; n++) step(13 + n, n, -n);
    idle();

    // Recal collides with a sample
    step(20, 0, 0, 1'b1, 1'b1);
    chk("recal_no_out", int'(out_valid), 0);
    chk("recal_cal_low", int'(calibrated), 0);
    chk("recal_bias_held", s16(bias_x), 13);
    for (int n = 0; n < 4; n++) step(50, 0, 100);
    idle();
    chk("bias_x_50", s16(bias_x), 50);
    step(0, 0, -32768);
    chk("gz_sat_neg", s16(gz), -32768);

    // Deadband boundary with bias 13
    step(0, 0, 0, 1'b0, 1'b1);
    step(10, 0, 0); step(12, 0, 0); step(14, 0, 0); step(16, 0, 0);
    idle();
    step(16, 0, 0);
`ifdef GYRO_DEADBAND_EN
    chk("deadband_16", s16(gx), 0);
`else
    chk("deadband_16", s16(gx), 3);
`endif
    step(17, 0, 0);
    chk("deadband_17", s16(gx), 4);

    // Reset in the middle of a recalibration restarts the count
    step(0, 0, 0, 1'b0, 1'b1);
    step(50, 50, 50); step(50, 50, 50);
    step(0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("midreset_bias", s16(bias_x), 0);
    chk("midreset_gx", s16(gx), 0);
    chk("midreset_cal", int'(calibrated), 0);
    step(7, 7, 7); step(7, 7, 7);
    idle();
    chk("count_restarted", int'(calibrated), 0);
    step(7, 7, 7); step(7, 7, 7);
    idle();
    chk("bias_after_restart", s16(bias_x), 7);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 0) rv[i] = s16(16'($urandom));
        else rv[i] = $urandom_range(0, 40) - 20;
      end
      v  = ($urandom_range(0, 9) < 7);
      rc = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 399) == 0);
      step(rv[0], rv[1], rv[2], v, rc, rs);
    end

    idle(); idle(); idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
